// File: rtl/i2c_cond_gen_pkg.sv
// Shared constants for the I2C bus-condition generator: command codes,
// FSM state encoding, per-phase {sda,scl} drive values and phase sequencing.
package i2c_cond_pkg;

    localparam logic [1:0] CMD_START  = 2'd0;
    localparam logic [1:0] CMD_RSTART = 2'd1;
    localparam logic [1:0] CMD_STOP   = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_SETUP = 3'd2,
        ST_HOLD  = 3'd3,
        ST_TAIL  = 3'd4
    } state_t;

    // Drive pairs are {sda, scl}; 1 = release, 0 = pull low.
    localparam logic [1:0] DRV_RELEASE  = 2'b11;
    localparam logic [1:0] DRV_RS_PRE   = 2'b10;
    localparam logic [1:0] DRV_SP_PRE   = 2'b00;
    localparam logic [1:0] DRV_ST_SETUP = 2'b11;
    localparam logic [1:0] DRV_SP_SETUP = 2'b01;
    localparam logic [1:0] DRV_ST_HOLD  = 2'b01;
    localparam logic [1:0] DRV_SP_HOLD  = 2'b11;
    localparam logic [1:0] DRV_TAIL     = 2'b00;

    function automatic logic is_illegal(input logic [1:0] code, input logic owned);
        logic bad;
        bad = 1'b0;
        if (code == CMD_START && owned)                      bad = 1'b1;
        if ((code == CMD_RSTART || code == CMD_STOP) && !owned) bad = 1'b1;
        if (code == 2'd3)                                    bad = 1'b1;
        return bad;
    endfunction

    function automatic state_t first_phase(input logic [1:0] code);
        return (code == CMD_START) ? ST_SETUP : ST_PRE;
    endfunction

    function automatic state_t next_phase(input state_t s, input logic [1:0] code);
        state_t n;
        case (s)
            ST_PRE:   n = ST_SETUP;
            ST_SETUP: n = ST_HOLD;
            ST_HOLD:  n = (code == CMD_STOP) ? ST_IDLE : ST_TAIL;
            default:  n = ST_IDLE;
        endcase
        return n;
    endfunction

    function automatic logic [1:0] phase_drive(input state_t s, input logic [1:0] code);
        logic [1:0] d;
        case (s)
            ST_PRE:   d = (code == CMD_STOP) ? DRV_SP_PRE   : DRV_RS_PRE;
            ST_SETUP: d = (code == CMD_STOP) ? DRV_SP_SETUP : DRV_ST_SETUP;
            ST_HOLD:  d = (code == CMD_STOP) ? DRV_SP_HOLD  : DRV_ST_HOLD;
            ST_TAIL:  d = DRV_TAIL;
            default:  d = DRV_RELEASE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/i2c_cond_gen_if.sv
// Command channel between the byte-level I2C master and the condition generator.
// Handshake: a command transfers on the rising clk edge where cmd_valid and
// cmd_ready are both 1; cmd_code must be stable while cmd_valid is high.
// done (and err with it) is a single-cycle completion pulse, no ready needed.
interface i2c_cond_gen_if #(
    parameter int CMD_W = 2
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CMD_W-1:0] cmd_code;
    logic             done;
    logic             err;

    modport master (
        output cmd_valid,
        output cmd_code,
        input  cmd_ready,
        input  done,
        input  err
    );

    modport slave (
        input  cmd_valid,
        input  cmd_code,
        output cmd_ready,
        output done,
        output err
    );
endinterface

// File: rtl/i2c_cond_gen_phase_timer.sv
// Phase length counter: loads len-1 on phase entry, counts down to 0 and
// reports expiry; stall freezes the count and holds off expiry.
module i2c_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             stall,
    output logic             expired
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (!stall && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expired = (cnt == '0) && !stall;
endmodule

// File: rtl/i2c_cond_gen.sv
// I2C START / repeated START / STOP generator with registered SCL/SDA drives.
// Optional CLK_STRETCH_EN: SETUP/HOLD phases stall while the slave holds SCL low.
module i2c_cond_gen
    import i2c_cond_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int CMD_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    i2c_cond_gen_if.slave    cmd,
    input  logic [CNT_W-1:0] cfg_t_su,
    input  logic [CNT_W-1:0] cfg_t_hd,
    input  logic [CNT_W-1:0] cfg_t_low,
    input  logic [CNT_W-1:0] cfg_t_buf,
    input  logic             scl_in,
    output logic             scl_out,
    output logic             sda_out,
    output logic             busy,
    output logic             owned,
    output state_t           dbg_state
);
    state_t           state, state_n;
    logic [1:0]       code_in, code_q;
    logic [CNT_W-1:0] su_q, hd_q, low_q, buf_q;
    logic [CNT_W-1:0] phase_cfg;
    logic [1:0]       drv_n;
    logic             owned_n, done_n, err_n, done_q, err_q;
    logic             latch, load, stall, expired;

    function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] c);
        return (c == '0) ? '0 : c - CNT_W'(1);
    endfunction

    assign code_in       = 2'(cmd.cmd_code);
    assign cmd.cmd_ready = (state == ST_IDLE);
    assign cmd.done      = done_q;
    assign cmd.err       = err_q;
    assign busy          = (state != ST_IDLE);
    assign dbg_state     = state;

`ifdef CLK_STRETCH_EN
    assign stall = (state == ST_SETUP || state == ST_HOLD) && !scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign stall         = 1'b0;
`endif

    i2c_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (len_m1(phase_cfg)),
        .stall    (stall),
        .expired  (expired)
    );

    // Lines are driven from the next state so they change on the same edge
    // as the state; IDLE keeps whatever the last phase left on the bus.
    always_comb begin
        state_n   = state;
        load      = 1'b0;
        latch     = 1'b0;
        phase_cfg = '0;
        drv_n     = {sda_out, scl_out};
        owned_n   = owned;
        done_n    = 1'b0;
        err_n     = 1'b0;
        if (state == ST_IDLE) begin
            if (cmd.cmd_valid) begin
                if (is_illegal(code_in, owned)) begin
                    done_n = 1'b1;
                    err_n  = 1'b1;
                end else begin
                    latch     = 1'b1;
                    load      = 1'b1;
                    state_n   = first_phase(code_in);
                    phase_cfg = (code_in == CMD_START) ? cfg_t_su : cfg_t_low;
                    drv_n     = phase_drive(first_phase(code_in), code_in);
                end
            end
        end else if (expired) begin
            state_n = next_phase(state, code_q);
            if (state_n == ST_IDLE) begin
                done_n  = 1'b1;
                owned_n = (code_q != CMD_STOP);
            end else begin
                load  = 1'b1;
                drv_n = phase_drive(state_n, code_q);
                case (state_n)
                    ST_PRE, ST_TAIL: phase_cfg = low_q;
                    ST_SETUP:        phase_cfg = su_q;
                    ST_HOLD:         phase_cfg = (code_q == CMD_STOP) ? buf_q : hd_q;
                    default:         phase_cfg = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            sda_out <= 1'b1;
            scl_out <= 1'b1;
            owned   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= CMD_START;
            su_q    <= '0;
            hd_q    <= '0;
            low_q   <= '0;
            buf_q   <= '0;
        end else begin
            state              <= state_n;
            {sda_out, scl_out} <= drv_n;
            owned              <= owned_n;
            done_q             <= done_n;
            err_q              <= err_n;
            if (latch) begin
                code_q <= code_in;
                su_q   <= cfg_t_su;
                hd_q   <= cfg_t_hd;
                low_q  <= cfg_t_low;
                buf_q  <= cfg_t_buf;
            end
        end
    end
endmodule

// File: tb/tb_i2c_cond_gen.sv
// Directed bench for i2c_cond_gen: command table with hand-computed phase
// sequences, plus reset-abort and clock-stretch sequences.
module tb_i2c_cond_gen;
    import i2c_cond_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0] cfg_t_su, cfg_t_hd, cfg_t_low, cfg_t_buf;
    logic       scl_in;
    logic       scl_out, sda_out, busy, owned;
    state_t     dbg_state;

    i2c_cond_gen_if #(.CMD_W(2)) cmd_if ();

    i2c_cond_gen #(.CNT_W(8), .CMD_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (cmd_if),
        .cfg_t_su  (cfg_t_su),
        .cfg_t_hd  (cfg_t_hd),
        .cfg_t_low (cfg_t_low),
        .cfg_t_buf (cfg_t_buf),
        .scl_in    (scl_in),
        .scl_out   (scl_out),
        .sda_out   (sda_out),
        .busy      (busy),
        .owned     (owned),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int         n_checks = 0;
    int         n_err    = 0;
    logic [1:0] exp_q[$];
    logic [1:0] cur_lines;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0] code;
        logic [7:0] su, hd, low, bf;
        int         n_ph;
        logic [1:0] drv [4];
        int         len [4];
        logic       exp_err;
        logic       exp_owned;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    task automatic set_vec(input int i, input logic [1:0] code,
                           input logic [7:0] su, input logic [7:0] hd,
                           input logic [7:0] low, input logic [7:0] bf,
                           input int n, input logic [7:0] drvs,
                           input int l0, input int l1, input int l2, input int l3,
                           input logic e, input logic own);
        vecs[i].code = code;
        vecs[i].su = su; vecs[i].hd = hd; vecs[i].low = low; vecs[i].bf = bf;
        vecs[i].n_ph = n;
        vecs[i].drv[0] = drvs[7:6]; vecs[i].drv[1] = drvs[5:4];
        vecs[i].drv[2] = drvs[3:2]; vecs[i].drv[3] = drvs[1:0];
        vecs[i].len[0] = l0; vecs[i].len[1] = l1; vecs[i].len[2] = l2; vecs[i].len[3] = l3;
        vecs[i].exp_err = e;
        vecs[i].exp_owned = own;
    endtask

    // ---------------- driver ----------------
    // Called at a negedge with the DUT idle; returns at the negedge of the done cycle.
    task automatic run_vec(input int i);
        logic [1:0] e;
        check($sformatf("v%0d ready", i), cmd_if.cmd_ready, 1'b1);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_code  = vecs[i].code;
        cfg_t_su = vecs[i].su; cfg_t_hd = vecs[i].hd;
        cfg_t_low = vecs[i].low; cfg_t_buf = vecs[i].bf;
        @(posedge clk);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        cfg_t_su  = 8'($urandom_range(0, 255));
        cfg_t_hd  = 8'($urandom_range(0, 255));
        cfg_t_low = 8'($urandom_range(0, 255));
        cfg_t_buf = 8'($urandom_range(0, 255));
        if (vecs[i].exp_err) begin
            check($sformatf("v%0d done/err", i), {cmd_if.done, cmd_if.err}, 2'b11);
            check($sformatf("v%0d lines", i), {sda_out, scl_out}, cur_lines);
            check($sformatf("v%0d busy", i), busy, 1'b0);
            check($sformatf("v%0d owned", i), owned, vecs[i].exp_owned);
        end else begin
            exp_q.delete();
            for (int p = 0; p < vecs[i].n_ph; p++)
                for (int k = 0; k < vecs[i].len[p]; k++)
                    exp_q.push_back(vecs[i].drv[p]);
            for (int c = 1; exp_q.size() > 0; c++) begin
                e = exp_q.pop_front();
                check($sformatf("v%0d cyc%0d {sda,scl,busy,done,ready}", i, c),
                      {sda_out, scl_out, busy, cmd_if.done, cmd_if.cmd_ready},
                      {e, 1'b1, 1'b0, 1'b0});
                @(negedge clk);
            end
            cur_lines = vecs[i].drv[vecs[i].n_ph-1];
            check($sformatf("v%0d done/err", i), {cmd_if.done, cmd_if.err}, 2'b10);
            check($sformatf("v%0d owned", i), owned, vecs[i].exp_owned);
            check($sformatf("v%0d idle lines", i), {sda_out, scl_out, busy}, {cur_lines, 1'b0});
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- test ----------------
    initial begin
        int setup_len;
        int guard;
        int exp_setup;

        //        idx code        su  hd  low bf   n  drv (4x{sda,scl})   lengths    err own
        set_vec(0,  CMD_STOP,   4,  3,  5,  6,  0, 8'b00_00_00_00,  0, 0, 0, 0, 1, 0);
        set_vec(1,  2'd3,       4,  3,  5,  6,  0, 8'b00_00_00_00,  0, 0, 0, 0, 1, 0);
        set_vec(2,  CMD_RSTART, 4,  3,  5,  6,  0, 8'b00_00_00_00,  0, 0, 0, 0, 1, 0);
        set_vec(3,  CMD_START,  4,  3,  5,  6,  3, 8'b11_01_00_00,  4, 3, 5, 0, 0, 1);
        set_vec(4,  CMD_START,  4,  3,  5,  6,  0, 8'b00_00_00_00,  0, 0, 0, 0, 1, 1);
        set_vec(5,  CMD_RSTART, 4,  3,  5,  6,  4, 8'b10_11_01_00,  5, 4, 3, 5, 0, 1);
        set_vec(6,  CMD_STOP,   4,  3,  5,  6,  3, 8'b00_01_11_00,  5, 4, 6, 0, 0, 0);
        set_vec(7,  CMD_START,  0,  0,  0,  0,  3, 8'b11_01_00_00,  1, 1, 1, 0, 0, 1);
        set_vec(8,  2'd3,       4,  3,  5,  6,  0, 8'b00_00_00_00,  0, 0, 0, 0, 1, 1);
        set_vec(9,  CMD_STOP,   0,  0,  0,  0,  3, 8'b00_01_11_00,  1, 1, 1, 0, 0, 0);
        set_vec(10, CMD_START,  2,  7,  1,  9,  3, 8'b11_01_00_00,  2, 7, 1, 0, 0, 1);
        set_vec(11, CMD_STOP,   2,  7,  1,  9,  3, 8'b00_01_11_00,  1, 2, 9, 0, 0, 0);

        rst = 1'b1;
        scl_in = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_code  = 2'd0;
        cfg_t_su = 8'd0; cfg_t_hd = 8'd0; cfg_t_low = 8'd0; cfg_t_buf = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset lines", {sda_out, scl_out}, 2'b11);
        check("reset ready", cmd_if.cmd_ready, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset owned", owned, 1'b0);
        check("reset done/err", {cmd_if.done, cmd_if.err}, 2'b00);
        check("reset state", dbg_state, ST_IDLE);
        cur_lines = 2'b11;

        // Back-to-back: each command is presented in the previous done cycle.
        for (int i = 0; i < NV; i++) run_vec(i);

        // Reset during HOLD of a START aborts without a STOP.
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_code  = CMD_START;
        cfg_t_su = 8'd4; cfg_t_hd = 8'd3; cfg_t_low = 8'd5; cfg_t_buf = 8'd6;
        @(posedge clk);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("abort pre lines", {sda_out, scl_out}, 2'b01);
        check("abort pre state", dbg_state, ST_HOLD);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort lines", {sda_out, scl_out}, 2'b11);
        check("abort owned", owned, 1'b0);
        check("abort ready/busy", {cmd_if.cmd_ready, busy}, 2'b10);
        check("abort done", cmd_if.done, 1'b0);

        // Slave holds SCL low for 7 clocks during SETUP of a START with t_su=4.
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_code  = CMD_START;
        cfg_t_su = 8'd4; cfg_t_hd = 8'd3; cfg_t_low = 8'd5; cfg_t_buf = 8'd6;
        @(posedge clk);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        scl_in = 1'b0;
        setup_len = 0;
        guard = 0;
        while ({sda_out, scl_out} == 2'b11 && busy && guard < 40) begin
            setup_len++;
            guard++;
            if (setup_len == 8) scl_in = 1'b1;
            @(negedge clk);
        end
        scl_in = 1'b1;
        guard = 0;
        while (!cmd_if.done && guard < 40) begin
            guard++;
            @(negedge clk);
        end
`ifdef CLK_STRETCH_EN
        exp_setup = 11;
`else
        exp_setup = 4;
`endif
        check("stretch setup length", setup_len, exp_setup);
        check("stretch done/err", {cmd_if.done, cmd_if.err}, 2'b10);
        check("stretch owned", owned, 1'b1);
        check("stretch final lines", {sda_out, scl_out}, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
